serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 103 ++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder -- bit-serial add/subtract built around one shared full-adder
// cell, processing operands LSB first, one bit per clock.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst      : synchronous, active-high reset
//   start    : begin an operation (only honoured while idle)
//   sub      : 0 = a+b, 1 = a-b (captured with start)
//   a, b     : WIDTH-bit operands (captured with start)
//   busy     : high while running or presenting the result
//   done     : one-cycle pulse, result valid from here on
//   sum      : WIDTH-bit result, held until the next accepted start
//   carry    : carry out of the MSB (for subtract: 1 = no borrow)
//   overflow : signed overflow
//
// Timing: start accepted on edge k -> WIDTH RUN cycles -> one DONE cycle.
// With start held high, operations repeat every WIDTH+2 cycles.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  // Counter must hold the value WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r, b_r;   // operands shift right; bit 0 is the live bit
  logic [WIDTH-1:0] sh;         // partial sum, filled from the top
  logic [CW-1:0]    cnt;
  logic             c;          // running carry

  logic             s_bit, c_nxt, last;
  logic [WIDTH-1:0] sh_nxt;

  assign s_bit  = a_r[0] ^ b_r[0] ^ c;
  assign c_nxt  = (a_r[0] & b_r[0]) | (a_r[0] & c) | (b_r[0] & c);
  assign last   = (cnt == CW'(WIDTH - 1));
  // New bit enters at the MSB; after WIDTH shifts bit i sits at position i.
  assign sh_nxt = (sh >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      sh       <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            // Subtract as a + ~b + 1: the +1 comes from the initial carry.
            b_r   <= sub ? ~b : b;
            c     <= sub;
            cnt   <= '0;
            sh    <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_r <= a_r >> 1;
          b_r <= b_r >> 1;
          c   <= c_nxt;
          sh  <= sh_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            // On the MSB step, c is the carry into the MSB.
            sum      <= sh_nxt;
            carry    <= c_nxt;
            overflow <= c ^ c_nxt;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
